// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern scheduler.
package led_pkg;

  localparam int unsigned NUM_REQ = 3;
  localparam logic [2:0]  CHASE_RST = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Next requester index in the 0 -> 1 -> 2 -> 0 ring.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/led_pattern_scheduler_tick_prescaler.sv
// Free-running divider producing a one-cycle display tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned    CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_q;

  // Wrap at TICK_DIV-1, otherwise count up.
  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
  end

  // Tick register is high exactly while the count sits at its terminal value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CNT_MAX);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_pattern_scheduler.sv
// Round-robin scheduler granting the 3 LEDs to one requester for a tick-counted display.
module led_pattern_scheduler
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 25_000_000,
  parameter int unsigned DUR_W      = 4,
  parameter int unsigned IDLE_CHASE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req,
  input  logic [2:0]       pat0,
  input  logic [2:0]       pat1,
  input  logic [2:0]       pat2,
  input  logic [DUR_W-1:0] dur0,
  input  logic [DUR_W-1:0] dur1,
  input  logic [DUR_W-1:0] dur2,
  output logic [2:0]       grant,
  output logic [2:0]       done,
  output logic             busy,
  output logic [2:0]       leds
);

  localparam logic [2:0] IDLE_LEDS_RST = (IDLE_CHASE != 0) ? CHASE_RST : 3'b000;

  state_e           state_q;
  logic [DUR_W-1:0] rem_q;
  logic [1:0]       last_q;
  logic [2:0]       chase_q;
  logic [2:0]       chase_d;
  logic [2:0]       pat_q;
  logic [2:0]       grant_q;
  logic [2:0]       done_q;
  logic             busy_q;
  logic [2:0]       leds_q;

  logic             tick;
  logic [1:0]       cand;
  logic [1:0]       win_idx;
  logic             win_vld;
  logic [2:0]       pat_sel;
  logic [DUR_W-1:0] dur_sel;
  logic [DUR_W-1:0] dur_eff;
  logic             owner_req;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Round-robin search starting after the last granted requester.
  always_comb begin
    win_idx = 2'd0;
    win_vld = 1'b0;
    cand    = rr_next(last_q);
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
      cand = rr_next(cand);
    end
  end

  // Select the winner's pattern and duration; a zero duration counts as one tick.
  always_comb begin
    pat_sel = pat0;
    dur_sel = dur0;
    case (win_idx)
      2'd1: begin pat_sel = pat1; dur_sel = dur1; end
      2'd2: begin pat_sel = pat2; dur_sel = dur2; end
      default: ;
    endcase
    dur_eff = (dur_sel == '0) ? DUR_W'(1) : dur_sel;
  end

  // Chase rotates 001 -> 010 -> 100 -> 001; owner still requesting keeps the display alive.
  always_comb begin
    chase_d   = {chase_q[1:0], chase_q[2]};
    owner_req = |(req & grant_q);
  end

  function automatic logic [2:0] idle_leds(input logic [2:0] chase);
    return (IDLE_CHASE != 0) ? chase : 3'b000;
  endfunction

  // Scheduler FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      last_q  <= 2'd2;
      chase_q <= CHASE_RST;
      pat_q   <= 3'b000;
      grant_q <= 3'b000;
      done_q  <= 3'b000;
      busy_q  <= 1'b0;
      leds_q  <= IDLE_LEDS_RST;
    end else begin
      done_q <= 3'b000;
      case (state_q)
        ST_IDLE: begin
          if (tick) chase_q <= chase_d;
          if (win_vld) begin
            state_q <= ST_SHOW;
            grant_q <= 3'b001 << win_idx;
            last_q  <= win_idx;
            pat_q   <= pat_sel;
            rem_q   <= dur_eff;
            busy_q  <= 1'b1;
            leds_q  <= pat_sel;
          end else begin
            leds_q  <= idle_leds(tick ? chase_d : chase_q);
          end
        end
        ST_SHOW: begin
          if (!owner_req) begin
            // Abort takes priority over a coincident final tick.
            state_q <= ST_IDLE;
            grant_q <= 3'b000;
            busy_q  <= 1'b0;
            leds_q  <= idle_leds(chase_q);
          end else begin
            leds_q <= pat_q;
            if (tick) begin
              if (rem_q == DUR_W'(1)) begin
                state_q <= ST_DONE;
                done_q  <= grant_q;
                grant_q <= 3'b000;
              end else begin
                rem_q <= rem_q - DUR_W'(1);
              end
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          leds_q  <= idle_leds(chase_q);
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= 3'b000;
          busy_q  <= 1'b0;
          leds_q  <= idle_leds(chase_q);
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign leds  = leds_q;

endmodule

// File: doc/led_pattern_scheduler.md
LED_PATTERN_SCHEDULER -- requirements
Module: led_pattern_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 25_000_000: clk cycles per display tick (0.5 s at 50 MHz); legal range 2 and above.
REQ-002 Parameter DUR_W, default 4: width of the per-requester duration fields.
REQ-003 Parameter IDLE_CHASE, default 1: 1 = rotating chase while idle; 0 = LEDs dark while idle.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 req  in  3  per-requester display request, level; bit i = requester i.
REQ-007 pat0, pat1, pat2  in  3 each  LED pattern requested by requester 0/1/2.
REQ-008 dur0, dur1, dur2  in  DUR_W each  display length in ticks; 0 SHALL be treated as 1.
REQ-009 grant  out  3  one-hot owner of the LEDs; 000 when no owner.
REQ-010 done  out  3  one-cycle pulse on bit i when requester i's display completes normally.
REQ-011 busy  out  1  high while the FSM is in SHOW or DONE.
REQ-012 leds  out  3  LED drive, active-high.

Function
REQ-013 Prescaler: free-running counter 0..TICK_DIV-1; tick SHALL pulse for one cycle when count = TICK_DIV-1, then count wraps to 0; independent of FSM state.
REQ-014 FSM states: IDLE, SHOW, DONE; encoding in the shared package.
REQ-015 IDLE with req=000: stay in IDLE; grant=000; busy=0.
REQ-016 IDLE with req!=000: next cycle SHALL enter SHOW with grant set to the round-robin winner; pattern and duration SHALL be latched in that same edge.
REQ-017 Round-robin: search order starts at (last_grant+1) mod 3; last_grant updates on every grant; reset value 2, so requester 0 wins first.
REQ-018 SHOW: leds = latched pattern; remaining count decrements on each tick.
REQ-019 SHOW with remaining = 1 and a tick: next state DONE.
REQ-020 Duration semantics: the first tick may be partial, so on-time SHALL lie in ((dur-1)*TICK_DIV, dur*TICK_DIV] cycles.
REQ-021 DONE, one cycle only: done[i]=1; grant=000; leds = latched pattern; next state IDLE.
REQ-022 Abort: if req[owner] drops while in SHOW, the FSM SHALL return to IDLE next cycle, with no done pulse and grant=000.
REQ-023 Abort and final tick in the same cycle: abort wins, no done pulse.
REQ-024 Changes to pat*/dur* after grant SHALL be ignored until the next grant.
REQ-025 An owner that still holds req after DONE SHALL be re-arbitrated from IDLE in round-robin order, with no back-to-back starvation of other requesters.
REQ-026 Idle chase (IDLE_CHASE=1): register cycles 001 -> 010 -> 100 -> 001 on each tick while in IDLE; it SHALL freeze outside IDLE and resume from its held value.
REQ-027 leds in IDLE = chase register (IDLE_CHASE=1) or 000 (IDLE_CHASE=0).
REQ-028 All outputs SHALL be functions of registered state only; no combinational path from input to output.

Reset
REQ-029 While rst=1 at a clk edge, the following SHALL be set: state=IDLE, prescaler=0, remaining=0, last_grant=2, chase=001, latched pattern=000.
REQ-030 Reset output values SHALL be: grant=000, done=000, busy=0, leds=001 (IDLE_CHASE=1) or 000 (IDLE_CHASE=0).
REQ-031 Reset asserted mid-SHOW or mid-DONE: the FSM SHALL abandon the display with no done pulse.

Structure
REQ-032 Package led_pkg SHALL hold the FSM state encoding, the chase reset value 3'b001, and the requester count constant 3.
REQ-033 Sub-module tick_prescaler (parameter TICK_DIV; ports clk, rst, tick) SHALL implement REQ-013.
REQ-034 Round-robin arbitration and the FSM SHALL live in led_pattern_scheduler; RTL budget is 120-400 lines.

Verification (TICK_DIV=4, DUR_W=4)
REQ-035 Idle: rst, then 24 cycles with no req -> leds sequence 001,010,100,001,... changing every 4 cycles; grant=000 throughout.
REQ-036 Single display: req=001, pat0=101, dur0=3 -> grant=001 one cycle later; leds=101 for 9-12 cycles; done=001 for exactly 1 cycle; grant=000 and busy=0 afterwards.
REQ-037 Round-robin: req=111 held, all dur=1 -> grant order 001,010,100,001 with a done pulse on each.
REQ-038 Abort: req0 drops 2 cycles into SHOW -> grant=000 next cycle; done never pulses; chase resumes from its frozen value.
REQ-039 Edge cases: dur0=0 -> behaves as dur0=1; pat0 changed mid-SHOW -> leds unchanged; req drop on the final-tick cycle -> no done pulse.
REQ-040 Reset mid-SHOW: rst for 1 cycle -> next cycle grant=000, done=000, busy=0, leds=001.
